// File: rtl/bk_pkg.sv
// bk_pkg: shared constants and types for the Brent-Kung prefix datapaths.
package bk_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int BK_SUB_LAT    = 3;

    // Generate/propagate pair carried through the prefix stage registers.
    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    // Ceiling log2, used for the number of prefix levels.
    function automatic int clog2(input int value);
        int result;
        int span;
        result = 0;
        span   = 1;
        while (span < value) begin
            span   = span * 2;
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/bk_black_cell.sv
// bk_black_cell: prefix combine of an upper span (g1,p1) with a lower span (g0,p0).
module bk_black_cell (
    input  logic g1,
    input  logic p1,
    input  logic g0,
    input  logic p0,
    output logic gg,
    output logic pp
);

    assign gg = g1 | (p1 & g0);
    assign pp = p1 & p0;

endmodule

// File: rtl/bk_sub_pipe.sv
// bk_sub_pipe: three-stage pipelined subtractor, d = a - b - bin, built on a
// Brent-Kung borrow prefix. S1 forms g/p, S2 holds the up-sweep, S3 holds the
// down-sweep result, borrow out and signed overflow.
module bk_sub_pipe
    import bk_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int LEVELS = clog2(WIDTH);

    logic stall;
    logic v1, v2, v3;

    // S1: per-bit generate/propagate of a + ~b, carry-in and operand sign bits.
    gp_t [WIDTH-1:0] s1_gp;
    logic            s1_c0;
    logic            s1_amsb;
    logic            s1_bmsb;

    // Up-sweep levels; level 0 has the carry-in folded into bit 0.
    gp_t [WIDTH-1:0] up [0:LEVELS];

    // S2: up-sweep result plus the original bit propagates for the sum XOR.
    gp_t [WIDTH-1:0]  s2_gp;
    logic [WIDTH-1:0] s2_p;
    logic             s2_c0;
    logic             s2_amsb;
    logic             s2_bmsb;

    // Down-sweep levels (generate only); the last level holds every carry.
    logic [WIDTH-1:0] dn [0:LEVELS-1];
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] diff_c;
    logic             bout_c;
    logic             ovf_c;

    // A result held at the output freezes every stage, empty ones included.
    assign stall     = v3 & ~out_ready;
    assign in_ready  = ~stall;
    assign out_valid = v3;

    // ---------------- up-sweep (combinational from S1) ----------------
    for (genvar i = 0; i < WIDTH; i++) begin : g_lvl0
        if (i == 0) begin : g_fold
            assign up[0][i] = {s1_gp[i].g | (s1_gp[i].p & s1_c0), s1_gp[i].p};
        end else begin : g_copy
            assign up[0][i] = s1_gp[i];
        end
    end

    for (genvar l = 0; l < LEVELS; l++) begin : g_up
        localparam int SPAN = 1 << l;
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            if (((i + 1) % (2 * SPAN)) == 0) begin : g_black
                logic gg;
                logic pp;
                bk_black_cell u_cell (
                    .g1 (up[l][i].g),
                    .p1 (up[l][i].p),
                    .g0 (up[l][i-SPAN].g),
                    .p0 (up[l][i-SPAN].p),
                    .gg (gg),
                    .pp (pp)
                );
                assign up[l+1][i] = {gg, pp};
            end else begin : g_pass
                assign up[l+1][i] = up[l][i];
            end
        end
    end

    // ---------------- down-sweep (combinational from S2) --------------
    for (genvar i = 0; i < WIDTH; i++) begin : g_dn0
        assign dn[0][i] = s2_gp[i].g;
    end

    for (genvar k = 0; k < LEVELS - 1; k++) begin : g_dn
        localparam int SPAN = 1 << (LEVELS - 2 - k);
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            if ((((i + 1) % (2 * SPAN)) == SPAN) && (i >= 3 * SPAN - 1)) begin : g_grey
                logic pp_unused;
                bk_black_cell u_cell (
                    .g1 (dn[k][i]),
                    .p1 (s2_gp[i].p),
                    .g0 (dn[k][i-SPAN]),
                    .p0 (1'b0),
                    .gg (dn[k+1][i]),
                    .pp (pp_unused)
                );
            end else begin : g_pass
                assign dn[k+1][i] = dn[k][i];
            end
        end
    end

    // Span propagates at the top of the tree are only needed on grey-cell rows.
    logic unused_span_p;
    assign unused_span_p = ^s2_gp;

    assign carry  = {dn[LEVELS-1], s2_c0};
    assign diff_c = s2_p ^ carry[WIDTH-1:0];
    assign bout_c = ~carry[WIDTH];
    assign ovf_c  = (s2_amsb != s2_bmsb) & (diff_c[WIDTH-1] != s2_amsb);

    // S1/S2 datapath registers advance together whenever the pipe is not stalled.
    // NOTE: these flops have no reset; they only matter when the matching valid
    // bit is set, and that bit is reset, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (!stall) begin
            for (int i = 0; i < WIDTH; i++) begin
                s1_gp[i].g <= a[i] & ~b[i];
                s1_gp[i].p <= ~(a[i] ^ b[i]);
                s2_p[i]    <= s1_gp[i].p;
            end
            s1_c0   <= ~bin;
            s1_amsb <= a[WIDTH-1];
            s1_bmsb <= b[WIDTH-1];
            s2_gp   <= up[LEVELS];
            s2_c0   <= s1_c0;
            s2_amsb <= s1_amsb;
            s2_bmsb <= s1_bmsb;
        end
    end

    // Valid chain and S3 output registers; reset clears every in-flight beat.
    // NOTE: non-blocking assignments make each stage take the previous stage's
    // pre-edge value; blocking ones would let a beat skip stages in one edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1   <= 1'b0;
            v2   <= 1'b0;
            v3   <= 1'b0;
            diff <= '0;
            bout <= 1'b0;
            ovf  <= 1'b0;
        end else if (!stall) begin
            v1   <= in_valid;
            v2   <= v1;
            v3   <= v2;
            diff <= diff_c;
            bout <= bout_c;
            ovf  <= ovf_c;
        end
    end

endmodule

// File: tb/tb_bk_sub_pipe.sv
// tb_bk_sub_pipe: directed and randomized checks of bk_sub_pipe against an
// arithmetic reference model and an in-order scoreboard.
module tb_bk_sub_pipe;
    import bk_pkg::*;

    localparam int W = 16;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;

    typedef struct {
        logic [W-1:0] diff;
        logic         bout;
        logic         ovf;
        int           acc;
    } exp_t;

    exp_t         sb_q[$];
    int           n_cmp = 0;
    int           n_err = 0;
    int           cyc = 0;
    bit           lat_check = 0;
    bit           held_v = 0;
    logic [W-1:0] held_diff;
    logic         held_bout;
    logic         held_ovf;

    bk_sub_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference: plain integer subtraction, unsigned for borrow, signed for overflow.
    function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin);
        exp_t        e;
        int unsigned ua;
        int unsigned ub;
        int          sa;
        int          sb;
        int          sd;
        ua     = 32'(ma);
        ub     = 32'(mb);
        sa     = int'($signed(ma));
        sb     = int'($signed(mb));
        sd     = sa - sb - int'(mbin);
        e.diff = W'(ua - ub - 32'(mbin));
        e.bout = (ua < ub + 32'(mbin));
        e.ovf  = (sd > 32767) || (sd < -32768);
        e.acc  = 0;
        return e;
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h8000;
            3:       return 16'h7FFF;
            default: return W'($urandom);
        endcase
    endfunction

    // Monitor: samples on the falling edge, when inputs and outputs are settled.
    always @(negedge clk) begin
        if (rst) begin
            sb_q.delete();
            held_v = 0;
        end else begin
            if (held_v) begin
                check("hold_valid", out_valid, 1);
                check("hold_diff", diff, held_diff);
                check("hold_bout", bout, held_bout);
                check("hold_ovf", ovf, held_ovf);
            end
            held_v    = out_valid && !out_ready;
            held_diff = diff;
            held_bout = bout;
            held_ovf  = ovf;
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("spurious_out", out_valid, 0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("diff", diff, e.diff);
                    check("bout", bout, e.bout);
                    check("ovf", ovf, e.ovf);
                    // Cycles from the accepting cycle to the first cycle the result is shown.
                    if (lat_check) check("latency", cyc - e.acc, BK_SUB_LAT);
                end
            end
            if (in_valid && in_ready) begin
                exp_t e;
                e     = model(a, b, bin);
                e.acc = cyc;
                sb_q.push_back(e);
            end
        end
    end

    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbin);
        int guard;
        guard    = 0;
        a        = ta;
        b        = tb;
        bin      = tbin;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) check("send_timeout", in_ready, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        a        = pick();
        b        = pick();
        bin      = 1'($urandom_range(0, 1));
    endtask

    task automatic drain();
        int guard;
        guard     = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (sb_q.size() != 0 && guard < 60) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1;
        check("drain_empty", sb_q.size(), 0);
    endtask

    task automatic rand_cycles(input int n, input bit rnd_ready);
        for (int k = 0; k < n; k++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            a         = pick();
            b         = pick();
            bin       = 1'($urandom_range(0, 1));
            out_ready = rnd_ready ? ($urandom_range(0, 9) < 7) : 1'b1;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        logic [3:0] idx;
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        bin       = 1'b0;
        out_ready = 1'b1;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_diff", diff, 0);
        check("rst_bout", bout, 0);
        check("rst_ovf", ovf, 0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // Directed values, including the borrow boundaries, with latency check.
        lat_check = 1;
        send(16'h0005, 16'h0003, 1'b0);
        send(16'h0000, 16'h0001, 1'b0);
        send(16'h8000, 16'h0001, 1'b0);
        send(16'h0000, 16'h0000, 1'b1);
        send(16'h0000, 16'hFFFF, 1'b1);
        send(16'h1234, 16'h1234, 1'b0);
        send(16'h7FFF, 16'hFFFF, 1'b0);
        idle();
        drain();

        // Back-to-back stream; the unit must never push back.
        for (int i = 0; i < 8; i++) begin
            idx = 4'(i);
            check("stream_ready", in_ready, 1);
            send(W'(i * 16'h1111), 16'h0101, idx[0]);
        end
        idle();
        drain();
        lat_check = 0;

        // Fill three stages with out_ready low, hold, then release.
        out_ready = 1'b0;
        send(16'h9ABC, 16'h1111, 1'b0);
        send(16'h4444, 16'h5555, 1'b1);
        send(16'hF00D, 16'h0F0D, 1'b0);
        idle();
        guard = 0;
        @(negedge clk);
        while (!out_valid && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) check("stall_wait_valid", out_valid, 1);
        for (int k = 0; k < 4; k++) begin
            check("stall_in_ready", in_ready, 0);
            check("stall_valid", out_valid, 1);
            if (sb_q.size() != 0) check("stall_diff_beat0", diff, sb_q[0].diff);
            if (k < 3) @(negedge clk);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("release_valid", out_valid, 1);
        end
        @(negedge clk);
        check("release_done", out_valid, 0);
        check("release_q_empty", sb_q.size(), 0);
        @(posedge clk);
        #1;

        // Reset with two beats in flight: nothing may emerge afterwards.
        send(16'h1357, 16'h0246, 1'b0);
        send(16'hABCD, 16'h0123, 1'b1);
        idle();
        rst = 1'b1;
        #1;
        check("flush_out_valid", out_valid, 0);
        check("flush_diff", diff, 0);
        check("flush_bout", bout, 0);
        check("flush_ovf", ovf, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("flush_in_ready", in_ready, 1);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("flush_no_out", out_valid, 0);
        end
        @(posedge clk);
        #1;

        // Random traffic at full throughput, with latency check.
        lat_check = 1;
        rand_cycles(150, 1'b0);
        idle();
        drain();
        lat_check = 0;

        // Random traffic with random backpressure.
        rand_cycles(500, 1'b1);
        idle();
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
